// File: rtl/uart_rx_buffer_if.sv
// uart_rx_buffer_if: receive strobes from the RX control FSM and the host-side FIFO port
interface uart_rx_buffer_if #(
  parameter int NUM_OF_BITS_IN_BUFFER = 8,
  parameter int ADDR_WIDTH            = 2
);
  logic                             in;
  logic                             receive;
  logic                             clear;
  logic                             rd_en;
  logic                             ovr_clr;
  logic [NUM_OF_BITS_IN_BUFFER-1:0] data_out;
  logic                             data_valid;
  logic                             full;
  logic [ADDR_WIDTH:0]              level;
  logic                             overrun;
  modport master (
    output in, receive, clear, rd_en, ovr_clr,
    input  data_out, data_valid, full, level, overrun
  );
  modport slave (
    input  in, receive, clear, rd_en, ovr_clr,
    output data_out, data_valid, full, level, overrun
  );
endinterface

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: assembles LSB-first RX words and queues them in a FWFT FIFO; UART_RX_BUF_OVERRUN_EN enables the sticky overrun flag
module uart_rx_buffer #(
  parameter int NUM_OF_BITS_IN_BUFFER = 8,
  parameter int FIFO_DEPTH            = 4,
  parameter int ADDR_WIDTH            = 2
) (
  input logic             clock,
  input logic             reset,
  uart_rx_buffer_if.slave b
);
  localparam int N  = NUM_OF_BITS_IN_BUFFER;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0]       LAST  = CW'(N - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
  logic [N-1:0]          shift_reg;
  logic [N-1:0]          mem [FIFO_DEPTH];
  logic [CW-1:0]         bit_cnt;
  logic                  push_pending;
  logic [ADDR_WIDTH-1:0] rd_ptr, wr_ptr;
  logic [ADDR_WIDTH:0]   level;
  logic                  empty, is_full, pop, push;
  assign empty   = level == '0;
  assign is_full = level == DEPTH;
  assign pop     = b.rd_en && !empty;
  assign push    = push_pending && (!is_full || pop);
  // shift in one data bit per strobe; the Nth strobe flags the word for a push next cycle
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      shift_reg    <= '0;
      bit_cnt      <= '0;
      push_pending <= 1'b0;
    end else begin
      push_pending <= b.receive && bit_cnt == LAST;
      if (b.receive) begin
        shift_reg <= {b.in, shift_reg[N-1:1]};
        bit_cnt   <= bit_cnt == LAST ? '0 : bit_cnt + CW'(1);
      end else if (b.clear)
        bit_cnt <= '0;
    end
  // word storage carries no reset; only entries below level are ever observed
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= shift_reg;
  // pointers wrap naturally at the power-of-two depth; level disambiguates full from empty
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, pop};
    end
  assign b.data_out   = empty ? '0 : mem[rd_ptr];
  assign b.data_valid = !empty;
  assign b.full       = is_full;
  assign b.level      = level;
`ifdef UART_RX_BUF_OVERRUN_EN
  logic overrun;
  // sticky drop flag; a drop in the same cycle as ovr_clr keeps it set
  always_ff @(posedge clock or negedge reset)
    if (!reset) overrun <= 1'b0;
    else overrun <= (push_pending && !push) || (overrun && !b.ovr_clr);
  assign b.overrun = overrun;
`else
  assign b.overrun = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb_uart_rx_buffer: table-driven frame/pop vectors plus hand-written latency and reset sequences
module tb_uart_rx_buffer;
`ifdef UART_RX_BUF_OVERRUN_EN
  localparam logic O = 1'b1;
`else
  localparam logic O = 1'b0;
`endif
  typedef enum {FRAME, PART, POP, CLR, FRMRD, FRMCLR, RSTP} op_t;
  typedef struct {
    op_t        op;
    logic [7:0] d;
    logic [7:0] ed;
    logic       ev;
    logic       ef;
    logic [2:0] el;
    logic       eo;
  } vec_t;
  logic clock, reset;
  int   n_vec, n_bad;
  vec_t tbl[$];
  uart_rx_buffer_if #(.NUM_OF_BITS_IN_BUFFER(8), .ADDR_WIDTH(2)) bus ();
  uart_rx_buffer #(.NUM_OF_BITS_IN_BUFFER(8), .FIFO_DEPTH(4), .ADDR_WIDTH(2)) dut (
    .clock(clock),
    .reset(reset),
    .b    (bus)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic tick(input logic i, r, c, rd, oc);
    bus.in      = i;
    bus.receive = r;
    bus.clear   = c;
    bus.rd_en   = rd;
    bus.ovr_clr = oc;
    @(negedge clock);
  endtask
  task automatic strobes(input logic [7:0] d, input int n);
    for (int k = 0; k < n; k++) tick(d[k], 1'b1, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic check(input string nm, input logic [7:0] ed, input logic ev, ef, input logic [2:0] el, input logic eo);
    n_vec++;
    if (bus.data_out !== ed || bus.data_valid !== ev || bus.full !== ef || bus.level !== el || bus.overrun !== eo) begin
      n_bad++;
      $display("FAIL %s: got data=%h valid=%b full=%b level=%0d ovr=%b, expected data=%h valid=%b full=%b level=%0d ovr=%b",
               nm, bus.data_out, bus.data_valid, bus.full, bus.level, bus.overrun, ed, ev, ef, el, eo);
    end
  endtask
  task automatic a(input op_t op, input logic [7:0] d, ed, input logic ev, ef, input logic [2:0] el, input logic eo);
    tbl.push_back('{op, d, ed, ev, ef, el, eo});
  endtask
  task automatic apply(input vec_t v);
    case (v.op)
      FRAME:  begin strobes(v.d, 8); tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); end
      PART:   begin strobes(v.d, 3); tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); end
      POP:    begin tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0); tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); end
      CLR:    begin tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1); tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); end
      FRMRD:  begin strobes(v.d, 8); tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0); tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); end
      FRMCLR: begin strobes(v.d, 8); tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1); tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); end
      RSTP: begin
        strobes(v.d, 4);
        reset = 1'b0;
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      default: ;
    endcase
  endtask
  initial begin
    n_vec = 0;
    n_bad = 0;
    a(POP,    8'h00, 8'h00, 0, 0, 0, 0);
    a(PART,   8'hFF, 8'h00, 0, 0, 0, 0);
    a(FRAME,  8'h3C, 8'h3C, 1, 0, 1, 0);
    a(POP,    8'h00, 8'h00, 0, 0, 0, 0);
    a(FRAME,  8'h01, 8'h01, 1, 0, 1, 0);
    a(FRAME,  8'h02, 8'h01, 1, 0, 2, 0);
    a(FRAME,  8'h03, 8'h01, 1, 0, 3, 0);
    a(FRAME,  8'h04, 8'h01, 1, 1, 4, 0);
    a(FRAME,  8'h05, 8'h01, 1, 1, 4, O);
    a(POP,    8'h00, 8'h02, 1, 0, 3, O);
    a(POP,    8'h00, 8'h03, 1, 0, 2, O);
    a(POP,    8'h00, 8'h04, 1, 0, 1, O);
    a(POP,    8'h00, 8'h00, 0, 0, 0, O);
    a(POP,    8'h00, 8'h00, 0, 0, 0, O);
    a(CLR,    8'h00, 8'h00, 0, 0, 0, 0);
    a(FRAME,  8'h11, 8'h11, 1, 0, 1, 0);
    a(FRAME,  8'h22, 8'h11, 1, 0, 2, 0);
    a(FRAME,  8'h33, 8'h11, 1, 0, 3, 0);
    a(FRAME,  8'h44, 8'h11, 1, 1, 4, 0);
    a(FRMRD,  8'h55, 8'h22, 1, 1, 4, 0);
    a(POP,    8'h00, 8'h33, 1, 0, 3, 0);
    a(POP,    8'h00, 8'h44, 1, 0, 2, 0);
    a(POP,    8'h00, 8'h55, 1, 0, 1, 0);
    a(POP,    8'h00, 8'h00, 0, 0, 0, 0);
    a(FRMRD,  8'h5A, 8'h5A, 1, 0, 1, 0);
    a(POP,    8'h00, 8'h00, 0, 0, 0, 0);
    a(FRAME,  8'h77, 8'h77, 1, 0, 1, 0);
    a(RSTP,   8'h0F, 8'h00, 0, 0, 0, 0);
    a(FRAME,  8'hC3, 8'hC3, 1, 0, 1, 0);
    a(POP,    8'h00, 8'h00, 0, 0, 0, 0);
    a(FRAME,  8'h61, 8'h61, 1, 0, 1, 0);
    a(FRAME,  8'h62, 8'h61, 1, 0, 2, 0);
    a(FRAME,  8'h63, 8'h61, 1, 0, 3, 0);
    a(FRAME,  8'h64, 8'h61, 1, 1, 4, 0);
    a(FRMCLR, 8'h65, 8'h61, 1, 1, 4, O);
    a(POP,    8'h00, 8'h62, 1, 0, 3, O);
    a(CLR,    8'h00, 8'h62, 1, 0, 3, 0);
    a(POP,    8'h00, 8'h63, 1, 0, 2, 0);
    a(POP,    8'h00, 8'h64, 1, 0, 1, 0);
    a(POP,    8'h00, 8'h00, 0, 0, 0, 0);
    bus.in      = 1'b0;
    bus.receive = 1'b0;
    bus.clear   = 1'b1;
    bus.rd_en   = 1'b0;
    bus.ovr_clr = 1'b0;
    reset       = 1'b0;
    repeat (3) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("reset", 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
    strobes(8'hA5, 8);
    check("latency_edge1", 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("latency_edge2", 8'hA5, 1'b1, 1'b0, 3'd1, 1'b0);
    foreach (tbl[i]) begin
      apply(tbl[i]);
      check($sformatf("vec%0d_%s_%h", i, tbl[i].op.name(), tbl[i].d), tbl[i].ed, tbl[i].ev, tbl[i].ef, tbl[i].el, tbl[i].eo);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
